// File: rtl/cond_it_unit_if.sv
// Execute-stage control/flag bundle between decode, ALU and the condition/IT unit.
// The master drives instruction and ALU fields; the slave returns execute and sequencer state.
interface cond_it_unit_if #(
    parameter int FLAG_W   = 5,
    parameter int IT_DEPTH = 4,
    parameter int CNT_W    = $clog2(IT_DEPTH + 1)
);
    logic                adv_i;
    logic                flush_i;
    logic [3:0]          cond_i;
    logic [FLAG_W-1:0]   alu_flags_i;
    logic [2:0]          flags_write_i;
    logic                flags_we_i;
    logic [FLAG_W-1:0]   flags_wdata_i;
    logic                it_start_i;
    logic [3:0]          it_firstcond_i;
    logic [CNT_W-1:0]    it_len_i;
    logic [IT_DEPTH-1:0] it_te_i;

    logic                cond_ex_o;
    logic [FLAG_W-1:0]   flags_o;
    logic                it_active_o;
    logic [3:0]          it_cond_o;
    logic [CNT_W-1:0]    it_remaining_o;
    logic                it_err_o;

    modport master (
        output adv_i, flush_i, cond_i, alu_flags_i, flags_write_i, flags_we_i,
               flags_wdata_i, it_start_i, it_firstcond_i, it_len_i, it_te_i,
        input  cond_ex_o, flags_o, it_active_o, it_cond_o, it_remaining_o, it_err_o
    );

    modport slave (
        input  adv_i, flush_i, cond_i, alu_flags_i, flags_write_i, flags_we_i,
               flags_wdata_i, it_start_i, it_firstcond_i, it_len_i, it_te_i,
        output cond_ex_o, flags_o, it_active_o, it_cond_o, it_remaining_o, it_err_o
    );
endinterface

// File: rtl/cond_it_unit.sv
// Flag register {Q,N,Z,C,V}, condition evaluation and IT-block sequencer for the Execute stage.
// cond_ex_o is combinational; flag and sequencer updates land one cycle after an adv_i edge.
module cond_it_unit #(
    parameter int FLAG_W   = 5,
    parameter int IT_DEPTH = 4,
    parameter int CNT_W    = $clog2(IT_DEPTH + 1)
) (
    input  logic           clk,
    input  logic           reset,
    cond_it_unit_if.slave  bus
);
    localparam int SLOT_W = $clog2(IT_DEPTH);
    localparam int Q_B = 4;
    localparam int N_B = 3;
    localparam int Z_B = 2;
    localparam int C_B = 1;
    localparam int V_B = 0;

    typedef enum logic [0:0] {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t              r_state, w_nxt_state;
    logic [SLOT_W-1:0]   r_slot, w_nxt_slot;
    logic [CNT_W-1:0]    r_remaining, w_nxt_remaining;
    logic [3:0]          r_firstcond, w_nxt_firstcond;
    logic [IT_DEPTH-1:0] r_te, w_nxt_te;
    logic                r_err, w_nxt_err;
    logic [FLAG_W-1:0]   r_flags;

    logic [3:0]          w_it_cond;
    logic [3:0]          w_eff_cond;
    logic                w_cond_ex;
    logic                w_len_ok;
    logic                w_start_ok;

    // Low bit of the code inverts the base test; 111x gives always/never.
    function automatic logic f_cond_pass(input logic [3:0] c, input logic [FLAG_W-1:0] f);
        logic base;
        unique case (c[3:1])
            3'b000:  base = f[Z_B];
            3'b001:  base = f[C_B];
            3'b010:  base = f[N_B];
            3'b011:  base = f[V_B];
            3'b100:  base = f[C_B] & ~f[Z_B];
            3'b101:  base = (f[N_B] == f[V_B]);
            3'b110:  base = ~f[Z_B] & (f[N_B] == f[V_B]);
            default: base = 1'b1;
        endcase
        return base ^ c[0];
    endfunction

    always_comb begin
        w_it_cond = 4'b1110;
        if (r_state == ACTIVE)
            w_it_cond = r_te[r_slot] ? r_firstcond : {r_firstcond[3:1], ~r_firstcond[0]};
    end

    assign w_eff_cond = (r_state == ACTIVE) ? w_it_cond : bus.cond_i;
    assign w_cond_ex  = f_cond_pass(w_eff_cond, r_flags);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flags <= '0;
        end else if (bus.adv_i) begin
            if (bus.flags_we_i) begin
                r_flags <= bus.flags_wdata_i;
            end else if (w_cond_ex) begin
                if (bus.flags_write_i[0]) begin
                    r_flags[C_B] <= bus.alu_flags_i[C_B];
                    r_flags[V_B] <= bus.alu_flags_i[V_B];
                end
                if (bus.flags_write_i[1]) begin
                    r_flags[N_B] <= bus.alu_flags_i[N_B];
                    r_flags[Z_B] <= bus.alu_flags_i[Z_B];
                end
                if (bus.flags_write_i[2])
                    r_flags[Q_B] <= r_flags[Q_B] | bus.alu_flags_i[Q_B];
            end
        end
    end

    assign w_len_ok   = (bus.it_len_i != '0) && (bus.it_len_i <= CNT_W'(IT_DEPTH));
    assign w_start_ok = (r_state == IDLE) && w_len_ok && bus.it_te_i[0]
                        && (bus.it_firstcond_i != 4'b1111);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_slot      <= '0;
            r_remaining <= '0;
            r_firstcond <= 4'b1110;
            r_te        <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_slot      <= w_nxt_slot;
            r_remaining <= w_nxt_remaining;
            r_firstcond <= w_nxt_firstcond;
            r_te        <= w_nxt_te;
            r_err       <= w_nxt_err;
        end
    end

    // Flush wins over both a new IT start and a slot advance.
    always_comb begin
        w_nxt_state     = r_state;
        w_nxt_slot      = r_slot;
        w_nxt_remaining = r_remaining;
        w_nxt_firstcond = r_firstcond;
        w_nxt_te        = r_te;
        w_nxt_err       = bus.adv_i & bus.it_start_i & ~w_start_ok;
        if (bus.flush_i) begin
            w_nxt_state     = IDLE;
            w_nxt_slot      = '0;
            w_nxt_remaining = '0;
        end else if (bus.adv_i) begin
            unique case (r_state)
                IDLE: begin
                    if (bus.it_start_i && w_start_ok) begin
                        w_nxt_state     = ACTIVE;
                        w_nxt_slot      = '0;
                        w_nxt_remaining = bus.it_len_i;
                        w_nxt_firstcond = bus.it_firstcond_i;
                        w_nxt_te        = bus.it_te_i;
                    end
                end
                ACTIVE: begin
                    if (r_remaining == CNT_W'(1)) begin
                        w_nxt_state     = IDLE;
                        w_nxt_slot      = '0;
                        w_nxt_remaining = '0;
                    end else begin
                        w_nxt_slot      = r_slot + 1'b1;
                        w_nxt_remaining = r_remaining - 1'b1;
                    end
                end
                default: w_nxt_state = IDLE;
            endcase
        end
    end

    assign bus.cond_ex_o      = w_cond_ex;
    assign bus.flags_o        = r_flags;
    assign bus.it_active_o    = (r_state == ACTIVE);
    assign bus.it_cond_o      = w_it_cond;
    assign bus.it_remaining_o = r_remaining;
    assign bus.it_err_o       = r_err;
endmodule

// File: tb/tb_cond_it_unit.sv
// Directed-vector bench for cond_it_unit with hand-computed expectations.
module tb_cond_it_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_total = 0;
    int   n_bad   = 0;

    always #5 clk = ~clk;

    cond_it_unit_if #(.FLAG_W(5), .IT_DEPTH(4)) u_if ();

    cond_it_unit #(.FLAG_W(5), .IT_DEPTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        u_if.adv_i          = 1'b0;
        u_if.flush_i        = 1'b0;
        u_if.cond_i         = 4'b1110;
        u_if.alu_flags_i    = '0;
        u_if.flags_write_i  = '0;
        u_if.flags_we_i     = 1'b0;
        u_if.flags_wdata_i  = '0;
        u_if.it_start_i     = 1'b0;
        u_if.it_firstcond_i = 4'b0000;
        u_if.it_len_i       = '0;
        u_if.it_te_i        = '0;
    endtask

    task automatic it_start(input logic [3:0] fc, input logic [2:0] len, input logic [3:0] te);
        u_if.adv_i          = 1'b1;
        u_if.it_start_i     = 1'b1;
        u_if.it_firstcond_i = fc;
        u_if.it_len_i       = len;
        u_if.it_te_i        = te;
    endtask

    task automatic write_flags(input logic [4:0] v);
        idle_inputs();
        u_if.adv_i         = 1'b1;
        u_if.flags_we_i    = 1'b1;
        u_if.flags_wdata_i = v;
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        #3;
        check("rst_flags", u_if.flags_o, 5'b00000);
        check("rst_active", u_if.it_active_o, 1'b0);
        check("rst_rem", u_if.it_remaining_o, 3'd0);
        check("rst_err", u_if.it_err_o, 1'b0);
        check("rst_itcond", u_if.it_cond_o, 4'b1110);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // EQ with Z=0 does not execute, so N,Z stay put
        u_if.cond_i = 4'b0000; u_if.alu_flags_i = 5'b00100;
        u_if.flags_write_i = 3'b010; u_if.adv_i = 1'b1;
        #1 check("eq_z0_ex", u_if.cond_ex_o, 1'b0);
        tick();
        check("eq_z0_flags", u_if.flags_o, 5'b00000);
        u_if.cond_i = 4'b1110;
        #1 check("al_ex", u_if.cond_ex_o, 1'b1);
        tick();
        check("al_flags", u_if.flags_o, 5'b00100);
        u_if.cond_i = 4'b0000; u_if.adv_i = 1'b0;
        #1 check("eq_z1_ex", u_if.cond_ex_o, 1'b1);

        // Q sticky
        u_if.cond_i = 4'b1110; u_if.adv_i = 1'b1;
        u_if.alu_flags_i = 5'b10000; u_if.flags_write_i = 3'b100;
        tick();
        check("q_set", u_if.flags_o, 5'b10100);
        u_if.alu_flags_i = 5'b00000;
        tick();
        check("q_sticky", u_if.flags_o, 5'b10100);
        write_flags(5'b00000);
        check("we_clear", u_if.flags_o, 5'b00000);
        u_if.flags_we_i = 1'b1; u_if.flags_wdata_i = 5'b11111; u_if.adv_i = 1'b0;
        tick();
        check("we_noadv", u_if.flags_o, 5'b00000);

        // IT EQ block, te=0101, Z=1
        write_flags(5'b00100);
        it_start(4'b0000, 3'd3, 4'b0101);
        u_if.cond_i = 4'b1110;
        #1 check("it_instr_ex", u_if.cond_ex_o, 1'b1);
        tick();
        idle_inputs();
        u_if.cond_i = 4'b1111; u_if.adv_i = 1'b1;
        #1 check("s0_active", u_if.it_active_o, 1'b1);
        check("s0_rem", u_if.it_remaining_o, 3'd3);
        check("s0_cond", u_if.it_cond_o, 4'b0000);
        check("s0_ex", u_if.cond_ex_o, 1'b1);
        tick();
        check("s1_rem", u_if.it_remaining_o, 3'd2);
        check("s1_cond", u_if.it_cond_o, 4'b0001);
        check("s1_ex", u_if.cond_ex_o, 1'b0);
        u_if.adv_i = 1'b0;
        tick();
        check("s1_hold_rem", u_if.it_remaining_o, 3'd2);
        u_if.adv_i = 1'b1;
        tick();
        check("s2_rem", u_if.it_remaining_o, 3'd1);
        check("s2_cond", u_if.it_cond_o, 4'b0000);
        check("s2_ex", u_if.cond_ex_o, 1'b1);
        tick();
        check("end_active", u_if.it_active_o, 1'b0);
        check("end_rem", u_if.it_remaining_o, 3'd0);
        check("end_cond", u_if.it_cond_o, 4'b1110);
        check("end_flags", u_if.flags_o, 5'b00100);

        // rejected starts
        idle_inputs();
        it_start(4'b0000, 3'd0, 4'b0001);
        tick();
        check("len0_err", u_if.it_err_o, 1'b1);
        check("len0_active", u_if.it_active_o, 1'b0);
        idle_inputs();
        tick();
        check("err_pulse", u_if.it_err_o, 1'b0);
        it_start(4'b0000, 3'd5, 4'b0001);
        tick();
        check("len5_err", u_if.it_err_o, 1'b1);
        it_start(4'b0000, 3'd2, 4'b0010);
        tick();
        check("te0_err", u_if.it_err_o, 1'b1);
        check("te0_active", u_if.it_active_o, 1'b0);
        it_start(4'b1111, 3'd2, 4'b0001);
        tick();
        check("fc15_err", u_if.it_err_o, 1'b1);

        // AL-based block: Else slot becomes never; restart while ACTIVE is rejected
        it_start(4'b1110, 3'd2, 4'b0001);
        tick();
        check("al_ok_err", u_if.it_err_o, 1'b0);
        check("al_rem", u_if.it_remaining_o, 3'd2);
        check("al_s0_ex", u_if.cond_ex_o, 1'b1);
        it_start(4'b0000, 3'd3, 4'b0111);
        tick();
        check("busy_err", u_if.it_err_o, 1'b1);
        check("busy_active", u_if.it_active_o, 1'b1);
        check("else_cond", u_if.it_cond_o, 4'b1111);
        check("else_ex", u_if.cond_ex_o, 1'b0);
        idle_inputs();
        u_if.adv_i = 1'b1;
        tick();
        check("busy_err_clr", u_if.it_err_o, 1'b0);
        check("al_done", u_if.it_active_o, 1'b0);

        // flush in slot 1 of a 4-long EQ block
        it_start(4'b0000, 3'd4, 4'b1111);
        tick();
        idle_inputs();
        u_if.adv_i = 1'b1;
        tick();
        check("fl_rem", u_if.it_remaining_o, 3'd3);
        u_if.flush_i = 1'b1; u_if.flags_write_i = 3'b011; u_if.alu_flags_i = 5'b01010;
        #1 check("fl_ex", u_if.cond_ex_o, 1'b1);
        tick();
        check("fl_flags", u_if.flags_o, 5'b01010);
        check("fl_active", u_if.it_active_o, 1'b0);
        check("fl_rem0", u_if.it_remaining_o, 3'd0);
        idle_inputs();
        u_if.cond_i = 4'b1111;
        #1 check("nv_ex", u_if.cond_ex_o, 1'b0);
        u_if.cond_i = 4'b1010;
        #1 check("ge_ex", u_if.cond_ex_o, 1'b0);
        u_if.cond_i = 4'b1011;
        #1 check("lt_ex", u_if.cond_ex_o, 1'b1);
        u_if.cond_i = 4'b1000;
        #1 check("hi_ex", u_if.cond_ex_o, 1'b1);
        u_if.cond_i = 4'b1101;
        #1 check("le_ex", u_if.cond_ex_o, 1'b1);

        // async reset in the middle of an IT block
        it_start(4'b1110, 3'd3, 4'b0001);
        tick();
        idle_inputs();
        u_if.adv_i = 1'b1;
        tick();
        idle_inputs();
        check("pre_rst_rem", u_if.it_remaining_o, 3'd2);
        reset = 1'b1;
        #1;
        check("arst_flags", u_if.flags_o, 5'b00000);
        check("arst_active", u_if.it_active_o, 1'b0);
        check("arst_rem", u_if.it_remaining_o, 3'd0);
        tick();
        reset = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
